// File: rtl/mole_game_core.sv
// Whack-a-mole game core: round FSM, BCD countdown, LFSR mole spawner with lifetime,
// one-hot hit detection and a saturating BCD score. Every output comes straight from a register.
module mole_game_core #(
   parameter int unsigned CLK_HZ     = 50_000_000,
   parameter int unsigned GAME_SEC   = 30,
   parameter int unsigned N_HOLES    = 9,
   parameter int unsigned MOLE_TICKS = 2,
   parameter int unsigned PENALTY    = 0,
   parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               inGame,
   input  logic [N_HOLES-1:0] hit,
   output logic               tick,
   output logic               playing,
   output logic               game_over,
   output logic               mole_valid,
   output logic [3:0]         position,
   output logic [3:0]         sec1,
   output logic [3:0]         sec2,
   output logic [3:0]         score1,
   output logic [3:0]         score2
);

   localparam int unsigned      CNT_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLK_HZ - 1);
   localparam logic [7:0]       SEC_INIT = 8'(((GAME_SEC / 10) << 4) | (GAME_SEC % 10));
   localparam logic [4:0]       NH       = 5'(N_HOLES);
   localparam logic [3:0]       AGE_MAX  = 4'(MOLE_TICKS);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_PLAY = 2'd1;
   localparam logic [1:0] ST_OVER = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       lfsr_q, lfsr_d;
   logic [3:0]       pos_q, pos_d;
   logic             mv_q, mv_d;
   logic [3:0]       age_q, age_d;
   logic [7:0]       sec_q, sec_d;
   logic [7:0]       score_q, score_d;
   logic             tick_q;
   logic             playing_q;
   logic             over_q;

   logic             tick_s;
   logic [15:0]      hit_ext_s;
   logic             hit_ok_s;
   logic             hit_bad_s;

   // Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1
   function automatic logic [7:0] lfsr_step(input logic [7:0] l);
      return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
   endfunction

   function automatic logic [3:0] pick_hole(input logic [7:0] l, input logic [3:0] cur);
      logic [4:0] c;
      c = {1'b0, l[3:0]} % NH;
      if (c[3:0] == cur) begin
         c = (c + 5'd1) % NH;
      end else begin
         c = c;
      end
      return c[3:0];
   endfunction

   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      logic [7:0] r;
      if (v == 8'h99) begin
         r = v;
      end else if (v[3:0] == 4'd9) begin
         r = {v[7:4] + 4'd1, 4'd0};
      end else begin
         r = {v[7:4], v[3:0] + 4'd1};
      end
      return r;
   endfunction

   function automatic logic [7:0] bcd_dec(input logic [7:0] v);
      logic [7:0] r;
      if (v == 8'h00) begin
         r = v;
      end else if (v[3:0] == 4'd0) begin
         r = {v[7:4] - 4'd1, 4'd9};
      end else begin
         r = {v[7:4], v[3:0] - 4'd1};
      end
      return r;
   endfunction

   assign hit_ext_s = 16'(hit);
   assign tick_s    = (state_q == ST_PLAY) && (cnt_q == CNT_MAX);
   assign hit_ok_s  = mv_q & hit_ext_s[pos_q];
   assign hit_bad_s = mv_q & (PENALTY != 0) & (|(hit_ext_s & ~(16'd1 << pos_q)));

   // Next-state logic for the round, timer, mole and score
   always_comb begin
      state_d = state_q;
      lfsr_d  = lfsr_step(lfsr_q);
      pos_d   = pos_q;
      mv_d    = mv_q;
      age_d   = age_q;
      sec_d   = sec_q;
      score_d = score_q;
      if (cnt_q == CNT_MAX) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      case (state_q)
         ST_IDLE: begin
            sec_d   = SEC_INIT;
            score_d = 8'h00;
            mv_d    = 1'b0;
            age_d   = 4'd0;
            if (inGame) begin
               state_d = ST_PLAY;
               cnt_d   = '0;
               pos_d   = pick_hole(lfsr_q, pos_q);
               mv_d    = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_PLAY: begin
            if (!inGame) begin
               state_d = ST_IDLE;
               sec_d   = SEC_INIT;
               score_d = 8'h00;
               mv_d    = 1'b0;
               age_d   = 4'd0;
            end else begin
               // a correct hit beats any wrong bits arriving with it
               if (hit_ok_s) begin
                  score_d = bcd_inc(score_q);
                  mv_d    = 1'b0;
               end else if (hit_bad_s) begin
                  score_d = bcd_dec(score_q);
               end else begin
                  score_d = score_q;
               end
               if (tick_s) begin
                  sec_d = bcd_dec(sec_q);
                  if (sec_q == 8'h01) begin
                     state_d = ST_OVER;
                     mv_d    = 1'b0;
                  end else if (hit_ok_s) begin
                     age_d = age_q;
                  end else if (mv_q) begin
                     if ((age_q + 4'd1) == AGE_MAX) begin
                        pos_d = pick_hole(lfsr_q, pos_q);
                        age_d = 4'd0;
                     end else begin
                        age_d = age_q + 4'd1;
                     end
                  end else begin
                     pos_d = pick_hole(lfsr_q, pos_q);
                     mv_d  = 1'b1;
                     age_d = 4'd0;
                  end
               end else begin
                  sec_d = sec_q;
               end
            end
         end
         ST_OVER: begin
            mv_d  = 1'b0;
            sec_d = 8'h00;
            if (!inGame) begin
               state_d = ST_IDLE;
               sec_d   = SEC_INIT;
               score_d = 8'h00;
            end else begin
               state_d = ST_OVER;
            end
         end
         default: begin
            state_d = ST_IDLE;
            mv_d    = 1'b0;
            age_d   = 4'd0;
            sec_d   = SEC_INIT;
            score_d = 8'h00;
         end
      endcase
   end

   // State and output registers; reset overrides every other event
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         lfsr_q    <= LFSR_SEED;
         pos_q     <= 4'd0;
         mv_q      <= 1'b0;
         age_q     <= 4'd0;
         sec_q     <= SEC_INIT;
         score_q   <= 8'h00;
         tick_q    <= 1'b0;
         playing_q <= 1'b0;
         over_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         lfsr_q    <= lfsr_d;
         pos_q     <= pos_d;
         mv_q      <= mv_d;
         age_q     <= age_d;
         sec_q     <= sec_d;
         score_q   <= score_d;
         tick_q    <= tick_s;
         playing_q <= (state_d == ST_PLAY);
         over_q    <= (state_d == ST_OVER);
      end
   end

   assign tick       = tick_q;
   assign playing    = playing_q;
   assign game_over  = over_q;
   assign mole_valid = mv_q;
   assign position   = pos_q;
   assign sec1       = sec_q[3:0];
   assign sec2       = sec_q[7:4];
   assign score1     = score_q[3:0];
   assign score2     = score_q[7:4];

endmodule

// File: tb/tb_mole_game_core.sv
// Directed bench for mole_game_core: a short-round instance (no penalty) and a
// 99-second instance with penalty; mole positions predicted from an LFSR reference.
module tb_mole_game_core;

   logic       clk;
   logic       rst;
   logic       in_game0, in_game1;
   logic [8:0] hit0, hit1;
   logic       tick0, playing0, over0, mv0;
   logic       tick1, playing1, over1, mv1;
   logic [3:0] pos0, s1_0, s2_0, c1_0, c2_0;
   logic [3:0] pos1, s1_1, s2_1, c1_1, c2_1;

   int n_chk  = 0;
   int n_pass = 0;

   logic [7:0] m_lfsr;
   logic [3:0] exp_pos0, exp_pos1, prev_pos;

   typedef struct {
      logic       in_game;
      logic [8:0] hit;
      logic       respawn;
      logic       tick;
      logic       playing;
      logic       over;
      logic       mv;
      logic [7:0] sec;
      logic [7:0] score;
   } vec_t;
   vec_t vq[$];

   mole_game_core #(.CLK_HZ(4), .GAME_SEC(3), .N_HOLES(9), .MOLE_TICKS(2),
                    .PENALTY(0), .LFSR_SEED(8'hA5)) u_dut0 (
      .clk(clk), .rst(rst), .inGame(in_game0), .hit(hit0), .tick(tick0),
      .playing(playing0), .game_over(over0), .mole_valid(mv0), .position(pos0),
      .sec1(s1_0), .sec2(s2_0), .score1(c1_0), .score2(c2_0));

   mole_game_core #(.CLK_HZ(2), .GAME_SEC(99), .N_HOLES(9), .MOLE_TICKS(2),
                    .PENALTY(1), .LFSR_SEED(8'hA5)) u_dut1 (
      .clk(clk), .rst(rst), .inGame(in_game1), .hit(hit1), .tick(tick1),
      .playing(playing1), .game_over(over1), .mole_valid(mv1), .position(pos1),
      .sec1(s1_1), .sec2(s2_1), .score1(c1_1), .score2(c2_1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference LFSR; both instances share reset so they share this sequence
   always @(posedge clk) begin
      if (rst) m_lfsr <= 8'hA5;
      else     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
   end

   function automatic logic [3:0] pick(input logic [7:0] l, input logic [3:0] cur);
      int c;
      c = int'(l[3:0]) % 9;
      if (c == int'(cur)) c = (c + 1) % 9;
      return 4'(c);
   endfunction

   function automatic logic [8:0] oh(input logic [3:0] p);
      logic [8:0] r;
      r = 9'd1 << p;
      return r;
   endfunction

   function automatic logic [7:0] bcd(input int n);
      return 8'(((n / 10) << 4) | (n % 10));
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic add(input logic ig, input logic [8:0] h, input logic rs, input logic tk,
                      input logic pl, input logic ov, input logic mv,
                      input logic [7:0] sec, input logic [7:0] sc);
      vec_t v;
      v.in_game = ig; v.hit = h; v.respawn = rs; v.tick = tk; v.playing = pl;
      v.over = ov; v.mv = mv; v.sec = sec; v.score = sc;
      vq.push_back(v);
   endtask

   initial begin
      rst = 1'b1; in_game0 = 1'b0; in_game1 = 1'b0; hit0 = '0; hit1 = '0;
      exp_pos0 = 4'd0; exp_pos1 = 4'd0; prev_pos = 4'd0;

      // idle with no request, one stray hit pattern, then a full round with no hits
      for (int i = 0; i < 20; i++) add(1'b0, (i == 10) ? 9'h1FF : 9'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h03, 8'h00);
      add(1'b1, 9'h000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h03, 8'h00);
      for (int i = 0; i < 3; i++) add(1'b1, 9'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h03, 8'h00);
      add(1'b1, 9'h000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h02, 8'h00);
      for (int i = 0; i < 3; i++) add(1'b1, 9'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h02, 8'h00);
      add(1'b1, 9'h000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h01, 8'h00);
      for (int i = 0; i < 3; i++) add(1'b1, 9'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 8'h00);
      add(1'b1, 9'h000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
      add(1'b1, 9'h1FF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
      add(1'b1, 9'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
      add(1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h03, 8'h00);
      add(1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h03, 8'h00);

      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      check("rst_tick", 8'(tick0), 8'd0);
      check("rst_playing", 8'(playing0), 8'd0);
      check("rst_over", 8'(over0), 8'd0);
      check("rst_mv", 8'(mv0), 8'd0);
      check("rst_pos", 8'(pos0), 8'd0);
      check("rst_sec", {s2_0, s1_0}, 8'h03);
      check("rst_score", {c2_0, c1_0}, 8'h00);
      check("rst_sec_d1", {s2_1, s1_1}, 8'h99);

      foreach (vq[i]) begin
         in_game0 = vq[i].in_game;
         hit0     = vq[i].hit;
         if (vq[i].respawn) exp_pos0 = pick(m_lfsr, exp_pos0);
         step();
         check("tbl_tick", 8'(tick0), 8'(vq[i].tick));
         check("tbl_playing", 8'(playing0), 8'(vq[i].playing));
         check("tbl_over", 8'(over0), 8'(vq[i].over));
         check("tbl_mv", 8'(mv0), 8'(vq[i].mv));
         check("tbl_sec", {s2_0, s1_0}, vq[i].sec);
         check("tbl_score", {c2_0, c1_0}, vq[i].score);
         if (vq[i].playing) begin
            check("tbl_pos", 8'(pos0), 8'(exp_pos0));
            check("tbl_pos_range", 8'(pos0 < 4'd9), 8'd1);
         end
      end
      hit0 = '0;

      // hit coinciding with a tick: scores, mole stays down until the following tick
      in_game0 = 1'b1; exp_pos0 = pick(m_lfsr, exp_pos0); step();
      check("a_enter_mv", 8'(mv0), 8'd1);
      run(3);
      hit0 = oh(exp_pos0); step(); hit0 = '0;
      check("a_tickhit_tick", 8'(tick0), 8'd1);
      check("a_tickhit_score", {c2_0, c1_0}, 8'h01);
      check("a_tickhit_mv", 8'(mv0), 8'd0);
      check("a_tickhit_pos", 8'(pos0), 8'(exp_pos0));
      run(3);
      check("a_still_down", 8'(mv0), 8'd0);
      prev_pos = exp_pos0; exp_pos0 = pick(m_lfsr, exp_pos0); step();
      check("a_respawn_mv", 8'(mv0), 8'd1);
      check("a_respawn_pos", 8'(pos0), 8'(exp_pos0));
      check("a_respawn_moved", 8'(pos0 != prev_pos), 8'd1);
      check("a_respawn_sec", {s2_0, s1_0}, 8'h01);
      hit0 = oh(exp_pos0); step(); hit0 = '0;
      check("a_hit2_score", {c2_0, c1_0}, 8'h02);
      check("a_hit2_mv", 8'(mv0), 8'd0);
      run(3);
      check("a_over", 8'(over0), 8'd1);
      check("a_over_score", {c2_0, c1_0}, 8'h02);
      in_game0 = 1'b0; step();
      check("a_idle_score", {c2_0, c1_0}, 8'h00);
      check("a_idle_sec", {s2_0, s1_0}, 8'h03);

      // hit in the tick cycle that ends the round
      in_game0 = 1'b1; exp_pos0 = pick(m_lfsr, exp_pos0); step();
      run(7);
      exp_pos0 = pick(m_lfsr, exp_pos0); step();
      check("c_respawn_pos", 8'(pos0), 8'(exp_pos0));
      run(3);
      hit0 = oh(exp_pos0); step(); hit0 = '0;
      check("c_last_score", {c2_0, c1_0}, 8'h01);
      check("c_last_over", 8'(over0), 8'd1);
      check("c_last_sec", {s2_0, s1_0}, 8'h00);
      in_game0 = 1'b0; step();

      // wrong hole ignored without penalty; abort clears the round
      in_game0 = 1'b1; exp_pos0 = pick(m_lfsr, exp_pos0); step();
      hit0 = oh(4'((exp_pos0 + 4'd1) % 4'd9)); step(); hit0 = '0;
      check("b_wrong_score", {c2_0, c1_0}, 8'h00);
      check("b_wrong_mv", 8'(mv0), 8'd1);
      hit0 = oh(exp_pos0); step(); hit0 = '0;
      check("b_hit_score", {c2_0, c1_0}, 8'h01);
      in_game0 = 1'b0; step();
      check("b_abort_playing", 8'(playing0), 8'd0);
      check("b_abort_score", {c2_0, c1_0}, 8'h00);
      check("b_abort_sec", {s2_0, s1_0}, 8'h03);

      // 99-second round hitting every mole: BCD countdown and score up to 99
      in_game1 = 1'b1; exp_pos1 = pick(m_lfsr, exp_pos1); step();
      check("d_enter_mv", 8'(mv1), 8'd1);
      for (int k = 1; k <= 198; k++) begin
         if (k % 2 == 1) hit1 = oh(exp_pos1);
         else if (k < 198) exp_pos1 = pick(m_lfsr, exp_pos1);
         step();
         hit1 = '0;
         if (k % 2 == 1) begin
            check("d_score", {c2_1, c1_1}, bcd((k + 1) / 2));
            check("d_mv_down", 8'(mv1), 8'd0);
         end else begin
            check("d_sec", {s2_1, s1_1}, bcd(99 - k / 2));
            if (k < 198) begin
               check("d_mv_up", 8'(mv1), 8'd1);
               check("d_pos", 8'(pos1), 8'(exp_pos1));
            end else begin
               check("d_over", 8'(over1), 8'd1);
            end
         end
      end
      hit1 = 9'h1FF; step(); hit1 = '0;
      check("d_over_hold", {c2_1, c1_1}, 8'h99);
      in_game1 = 1'b0; step();

      // penalty: wrong hits decrement with floor at 00, correct+wrong scores
      in_game1 = 1'b1; exp_pos1 = pick(m_lfsr, exp_pos1); step();
      hit1 = oh(exp_pos1); step(); hit1 = '0;
      check("p_hit_score", {c2_1, c1_1}, 8'h01);
      exp_pos1 = pick(m_lfsr, exp_pos1); step();
      check("p_respawn_pos", 8'(pos1), 8'(exp_pos1));
      hit1 = oh(4'((exp_pos1 + 4'd1) % 4'd9)); step(); hit1 = '0;
      check("p_wrong1_score", {c2_1, c1_1}, 8'h00);
      check("p_wrong1_mv", 8'(mv1), 8'd1);
      step();
      hit1 = oh(4'((exp_pos1 + 4'd1) % 4'd9)); step(); hit1 = '0;
      check("p_wrong2_score", {c2_1, c1_1}, 8'h00);
      exp_pos1 = pick(m_lfsr, exp_pos1); step();
      check("p_age_pos", 8'(pos1), 8'(exp_pos1));
      hit1 = oh(exp_pos1) | oh(4'((exp_pos1 + 4'd1) % 4'd9)); step(); hit1 = '0;
      check("p_both_score", {c2_1, c1_1}, 8'h01);
      check("p_both_mv", 8'(mv1), 8'd0);
      in_game1 = 1'b0; step();

      // reset during play with a simultaneous correct hit
      in_game0 = 1'b1; exp_pos0 = pick(m_lfsr, exp_pos0); step();
      hit0 = oh(exp_pos0); step(); hit0 = '0;
      check("r_pre_score", {c2_0, c1_0}, 8'h01);
      hit0 = oh(exp_pos0); rst = 1'b1; step(); rst = 1'b0; hit0 = '0;
      check("r_playing", 8'(playing0), 8'd0);
      check("r_mv", 8'(mv0), 8'd0);
      check("r_score", {c2_0, c1_0}, 8'h00);
      check("r_sec", {s2_0, s1_0}, 8'h03);
      check("r_pos", 8'(pos0), 8'd0);
      check("r_over", 8'(over0), 8'd0);
      in_game0 = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
